// File: rtl/display_suma_bcd.sv
// -----------------------------------------------------------------------------
// display_suma_bcd
//
// Purpose:
//   Captures the 5-bit total of a 4-bit adder ({Cout,S}, 0..31) on a load
//   strobe, converts it to two decimal digits with a sequential
//   repeated-subtraction FSM, and drives a 2-digit multiplexed common-anode
//   7-segment display with leading-zero blanking on the tens digit.
//   The display digits change only when a conversion completes, so the shown
//   value never flickers while a conversion is running.
//
// Parameters:
//   REFRESH_DIV : clock cycles per digit slot in the display multiplex (>= 2).
//
// Ports:
//   clk     in   1  system clock, rising-edge active
//   rst     in   1  asynchronous active-high reset
//   ST      in   5  adder total, unsigned 0..31
//   cargar  in   1  load strobe, level-sampled on clk
//   ocupado out  1  high while a conversion is in progress
//   listo   out  1  one-cycle pulse when the display digits update
//   seg     out  7  segments {g,f,e,d,c,b,a}, active-low
//   an      out  2  digit anodes, active-low; an[0]=units, an[1]=tens
// -----------------------------------------------------------------------------
module display_suma_bcd #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ST,
  input  logic       cargar,
  output logic       ocupado,
  output logic       listo,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  val;     // remainder being reduced by tens
  logic [1:0]  dec_w;   // working tens digit (0..3)
  logic [3:0]  uni_w;   // working units digit (0..9)
  logic [1:0]  tens;    // displayed tens digit
  logic [3:0]  units;   // displayed units digit
  logic [CW-1:0] cnt;   // refresh counter
  logic        sel;     // 0 = units slot, 1 = tens slot

  // Active-low gfedcba pattern for one decimal digit.
  function automatic logic [6:0] pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion FSM. ST is sampled only on the load edge; cargar is ignored
  // outside IDLE, so a strobe during a conversion is simply dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      val     <= 5'd0;
      dec_w   <= 2'd0;
      uni_w   <= 4'd0;
      tens    <= 2'd0;
      units   <= 4'd0;
      ocupado <= 1'b0;
      listo   <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: begin
          if (cargar) begin
            val     <= ST;
            dec_w   <= 2'd0;
            ocupado <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          // At most three subtractions (31 -> 21 -> 11 -> 1), so dec_w fits
          // in two bits and val never underflows.
          if (val >= 5'd10) begin
            val   <= val - 5'd10;
            dec_w <= dec_w + 2'd1;
          end else begin
            uni_w <= val[3:0];
            state <= DONE;
          end
        end
        DONE: begin
          tens    <= dec_w;
          units   <= uni_w;
          listo   <= 1'b1;
          ocupado <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh counter: free-running, independent of the FSM. sel toggles on the
  // wrap edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sel <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      sel <= ~sel;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered display drive. Uses the current sel and display digits, so a
  // digit update or slot change shows up one edge later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 2'b11;
      seg <= 7'b1111111;
    end else if (!sel) begin
      an  <= 2'b10;
      seg <= pattern(units);
    end else if (tens != 2'd0) begin
      an  <= 2'b01;
      seg <= pattern({2'b00, tens});
    end else begin
      // Leading zero on the tens digit: keep both anodes off.
      an  <= 2'b11;
      seg <= 7'b1111111;
    end
  end

endmodule
